vga_plot_arbiter: RTL and testbench

Shares the single pixel-write port of the 160x120 `vga_adapter` (x, y, colour, plot) among three drawing engines: screen fill, circle, and one spare. Arbitration is round-robin with burst ownership and bounded bursts. Pixels that fall off-screen are clipped and counted. The block sits between the drawing FSMs and `vga_adapter`, so the engines no longer drive the adapter port directly.

---
 rtl/vga_plot_arbiter.sv | 139 +++++++++++++
 tb/tb_vga_plot_arbiter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_arbiter.sv
// Round-robin owner of the vga_adapter pixel port, shared by three drawing engines.
// Grants whole bursts, bounds them, clips off-screen pixels and counts what it drops.
//
// state | meaning
// IDLE  | no owner, grant = 000, picking the next winner from req
// OWN   | grant = onehot(owner), pixels from the owner are forwarded
module vga_plot_arbiter #(
  parameter int SCREEN_WIDTH  = 160,
  parameter int SCREEN_HEIGHT = 120,
  parameter int MAX_BURST     = 64
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic [2:0]  req,
  input  logic [2:0]  pix_valid,
  input  logic [23:0] pix_x,
  input  logic [20:0] pix_y,
  input  logic [8:0]  pix_colour,
  output logic [2:0]  grant,
  output logic        busy,
  output logic [7:0]  vga_x,
  output logic [6:0]  vga_y,
  output logic [2:0]  vga_colour,
  output logic        vga_plot,
  output logic [15:0] clip_count
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [8:0] X_LIM      = 9'(SCREEN_WIDTH);
  localparam logic [7:0] Y_LIM      = 8'(SCREEN_HEIGHT);

  logic       state;
  logic [1:0] owner;
  logic [1:0] last;
  logic [1:0] winner;
  logic [1:0] pri1;
  logic [1:0] pri2;
  logic [7:0] burst_cnt;
  logic       accept;
  logic       others_req;
  logic       burst_end;
  logic       in_bounds;
  logic [7:0] sel_x;
  logic [6:0] sel_y;
  logic [2:0] sel_colour;

  function automatic logic [1:0] next_idx(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Search order last+1, last+2, last so the previous owner goes to the back.
  always_comb begin
    pri1   = next_idx(last);
    pri2   = next_idx(pri1);
    winner = last;
    if (req[pri1])      winner = pri1;
    else if (req[pri2]) winner = pri2;
  end

  always_comb begin
    sel_x      = pix_x[7:0];
    sel_y      = pix_y[6:0];
    sel_colour = pix_colour[2:0];
    case (owner)
      2'd1: begin
        sel_x      = pix_x[15:8];
        sel_y      = pix_y[13:7];
        sel_colour = pix_colour[5:3];
      end
      2'd2: begin
        sel_x      = pix_x[23:16];
        sel_y      = pix_y[20:14];
        sel_colour = pix_colour[8:6];
      end
      default: ;
    endcase
  end

  assign accept     = |(grant & pix_valid);
  assign others_req = |(req & ~grant);
  assign burst_end  = (burst_cnt == BURST_LAST);
  assign in_bounds  = ({1'b0, sel_x} < X_LIM) && ({1'b0, sel_y} < Y_LIM);
  assign busy       = |grant;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state      <= ST_IDLE;
      owner      <= 2'd0;
      last       <= 2'd2;
      grant      <= 3'b000;
      burst_cnt  <= 8'd0;
      clip_count <= 16'd0;
      vga_x      <= 8'd0;
      vga_y      <= 7'd0;
      vga_colour <= 3'd0;
      vga_plot   <= 1'b0;
    end else begin
      vga_plot <= 1'b0;
      if (accept) begin
        if (in_bounds) begin
          vga_x      <= sel_x;
          vga_y      <= sel_y;
          vga_colour <= sel_colour;
          vga_plot   <= 1'b1;
        end else if (clip_count != 16'hFFFF) begin
          clip_count <= clip_count + 16'd1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (|req) begin
            state     <= ST_OWN;
            owner     <= winner;
            last      <= winner;
            grant     <= 3'b001 << winner;
            burst_cnt <= 8'd0;
          end
        end
        ST_OWN: begin
          if (accept) burst_cnt <= burst_end ? 8'd0 : burst_cnt + 8'd1;
          // A full burst only yields when someone else is actually waiting.
          if (!req[owner] || (accept && burst_end && others_req)) begin
            state <= ST_IDLE;
            grant <= 3'b000;
          end
        end
        default: begin
          state <= ST_IDLE;
          grant <= 3'b000;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vga_plot_arbiter.sv
// Directed bench for vga_plot_arbiter built with MAX_BURST = 4 so burst rotation is short.
module tb_vga_plot_arbiter;

  logic        CLOCK_50;
  logic        reset;
  logic [2:0]  req;
  logic [2:0]  pix_valid;
  logic [23:0] pix_x;
  logic [20:0] pix_y;
  logic [8:0]  pix_colour;
  logic [2:0]  grant;
  logic        busy;
  logic [7:0]  vga_x;
  logic [6:0]  vga_y;
  logic [2:0]  vga_colour;
  logic        vga_plot;
  logic [15:0] clip_count;

  logic [7:0] px_x [3];
  logic [6:0] px_y [3];
  logic [2:0] px_c [3];

  int n_checks = 0;
  int n_pass   = 0;
  int plots    = 0;

  assign pix_x      = {px_x[2], px_x[1], px_x[0]};
  assign pix_y      = {px_y[2], px_y[1], px_y[0]};
  assign pix_colour = {px_c[2], px_c[1], px_c[0]};

  vga_plot_arbiter #(
    .SCREEN_WIDTH (160),
    .SCREEN_HEIGHT(120),
    .MAX_BURST    (4)
  ) dut (
    .CLOCK_50  (CLOCK_50),
    .reset     (reset),
    .req       (req),
    .pix_valid (pix_valid),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_colour(pix_colour),
    .grant     (grant),
    .busy      (busy),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_colour(vga_colour),
    .vga_plot  (vga_plot),
    .clip_count(clip_count)
  );

  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    else n_pass++;
  endtask

  task automatic set_pix(input int i, input int x, input int y, input int c);
    px_x[i] = x[7:0];
    px_y[i] = y[6:0];
    px_c[i] = c[2:0];
  endtask

  logic [2:0] exp_rot [16] = '{3'b001, 3'b001, 3'b001, 3'b001, 3'b000,
                               3'b010, 3'b010, 3'b010, 3'b010, 3'b000,
                               3'b100, 3'b100, 3'b100, 3'b100, 3'b000,
                               3'b001};
  int clip_xs [4] = '{159, 160, 0, 255};
  int clip_ys [4] = '{119, 0, 120, 127};
  logic clip_plot [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

  initial begin
    reset = 1'b1;
    req = 3'b000;
    pix_valid = 3'b000;
    for (int i = 0; i < 3; i++) set_pix(i, 0, 0, 0);
    tick();
    tick();
    reset = 1'b0;
    check("rst_grant", grant, 3'b000);
    check("rst_busy", busy, 1'b0);
    check("rst_plot", vga_plot, 1'b0);
    check("rst_xyc", {vga_x, vga_y, vga_colour}, 18'd0);
    check("rst_clip", clip_count, 16'd0);

    // Reset priority: requester 0 wins first and streams three pixels.
    req = 3'b111;
    tick();
    check("prio_grant", grant, 3'b001);
    check("prio_busy", busy, 1'b1);
    for (int i = 0; i < 3; i++) begin
      set_pix(0, 10 + i, 20, 1);
      pix_valid = 3'b001;
      tick();
      check("prio_plot", vga_plot, 1'b1);
      check("prio_x", vga_x, 10 + i);
      check("prio_y", vga_y, 20);
      check("prio_col", vga_colour, 1);
    end
    pix_valid = 3'b000;
    req = 3'b000;
    tick();
    check("prio_rel_grant", grant, 3'b000);
    check("prio_rel_plot", vga_plot, 1'b0);

    // Round-robin rotation with full bursts of 4.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) set_pix(i, 50 + i, 60, i + 1);
    req = 3'b111;
    tick();
    for (int i = 0; i < 16; i++) begin
      check("rot_grant", grant, exp_rot[i]);
      if (vga_plot) plots++;
      pix_valid = grant;
      tick();
    end
    check("rot_plots", plots, 12);
    req = 3'b000;
    pix_valid = 3'b000;
    tick();

    // No contention: requester 1 keeps the port across burst wraps.
    req = 3'b010;
    tick();
    check("solo_grant0", grant, 3'b010);
    for (int i = 0; i < 10; i++) begin
      set_pix(1, 30 + i, 40, 2);
      pix_valid = 3'b010;
      tick();
      check("solo_plot", vga_plot, 1'b1);
      check("solo_x", vga_x, 30 + i);
      check("solo_grant", grant, 3'b010);
    end
    pix_valid = 3'b000;
    req = 3'b000;
    tick();
    check("solo_rel", grant, 3'b000);

    // Clipping on the screen edges.
    req = 3'b100;
    tick();
    check("clip_grant", grant, 3'b100);
    for (int i = 0; i < 4; i++) begin
      set_pix(2, clip_xs[i], clip_ys[i], 3);
      pix_valid = 3'b100;
      tick();
      check("clip_plot", vga_plot, clip_plot[i]);
      check("clip_x", vga_x, 159);
      check("clip_y", vga_y, 119);
    end
    check("clip_count3", clip_count, 3);

    // Release with a pixel in the same cycle, then a valid without grant.
    set_pix(2, 5, 6, 4);
    pix_valid = 3'b100;
    req = 3'b000;
    tick();
    check("rel_plot", vga_plot, 1'b1);
    check("rel_xyc", {vga_x, vga_y, vga_colour}, {8'd5, 7'd6, 3'd4});
    check("rel_grant", grant, 3'b000);
    set_pix(0, 7, 7, 7);
    pix_valid = 3'b001;
    tick();
    check("ign_plot0", vga_plot, 1'b0);
    check("ign_grant", grant, 3'b000);
    tick();
    check("ign_plot1", vga_plot, 1'b0);
    check("ign_x", vga_x, 5);
    pix_valid = 3'b000;

    // Clip counter saturation.
    req = 3'b001;
    tick();
    check("sat_grant", grant, 3'b001);
    set_pix(0, 200, 0, 1);
    pix_valid = 3'b001;
    repeat (65531) tick();
    check("sat_pre", clip_count, 16'd65534);
    repeat (9) tick();
    check("sat_max", clip_count, 16'hFFFF);
    check("sat_plot", vga_plot, 1'b0);

    // Reset while owner 0 is streaming.
    set_pix(0, 1, 2, 5);
    tick();
    check("mid_plot", vga_plot, 1'b1);
    check("mid_x", vga_x, 1);
    reset = 1'b1;
    tick();
    check("mid_rst_grant", grant, 3'b000);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_plot", vga_plot, 1'b0);
    check("mid_rst_clip", clip_count, 16'd0);
    check("mid_rst_x", vga_x, 0);
    reset = 1'b0;
    pix_valid = 3'b000;
    req = 3'b111;
    tick();
    check("mid_next_grant", grant, 3'b001);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
